// File: rtl/pcs_sync_multi.sv
// 1000BASE-X code-group sync with programmable comma/good/bad thresholds; PCS_SYNC_STATS_EN adds loss/bad counters.
// Latency: 1 cycle, all outputs registered together and describing sync_code_group.
// Backpressure: none, one code-group is consumed every RX_CLK cycle.
module pcs_sync_multi #(
   parameter int ACQ_COMMAS = 3,
   parameter int GOOD_CGS   = 4,
   parameter int BAD_LIMIT  = 4,
   parameter int CNT_W      = 16
) (
   input  logic             RX_CLK,
   input  logic             mr_main_reset_n,
   input  logic             signal_detect,
   input  logic             mr_loopback,
   input  logic [9:0]       rx_code_group,
   input  logic             cg_invalid,
   output logic [9:0]       sync_code_group,
   output logic             sync_even,
   output logic             code_sync_status,
   output logic [1:0]       sync_state
`ifdef PCS_SYNC_STATS_EN
   ,
   output logic [CNT_W-1:0] loss_count,
   output logic [CNT_W-1:0] bad_cg_count
`endif
);

   typedef enum logic [1:0] {
      LOSS_OF_SYNC  = 2'd0,
      COMMA_DETECT  = 2'd1,
      ACQUIRE_SYNC  = 2'd2,
      SYNC_ACQUIRED = 2'd3
   } state_t;

   if (ACQ_COMMAS < 1 || ACQ_COMMAS > 7 || GOOD_CGS < 1 || GOOD_CGS > 15 ||
       BAD_LIMIT < 1 || BAD_LIMIT > 15 || CNT_W < 1) begin : g_param_check
      $error("pcs_sync_multi: parameter out of legal range");
   end

   state_t     state;
   logic [2:0] comma_cnt;
   logic [3:0] good_cnt;
   logic [3:0] bad_cnt;

   logic       signal_ok;
   logic       comma;
   logic       cgbad;
   logic       cggood;
   logic       data_ok;
   logic [3:0] good_inc;
   logic [3:0] bad_inc;
   logic       go_loss;
   logic       realign;

   // sync_even doubles as rx_even: cgbad must see the value before this cycle's update
   assign signal_ok = signal_detect | mr_loopback;
   assign comma     = (rx_code_group[9:3] == 7'b0011111) | (rx_code_group[9:3] == 7'b1100000);
   assign cgbad     = cg_invalid | (comma & sync_even);
   assign cggood    = ~cgbad;
   assign data_ok   = ~cg_invalid & ~comma;
   assign good_inc  = good_cnt + 4'd1;
   assign bad_inc   = bad_cnt + 4'd1;

   assign go_loss = ~signal_ok
                  | ((state == COMMA_DETECT)  & ~data_ok)
                  | ((state == ACQUIRE_SYNC)  & cgbad)
                  | ((state == SYNC_ACQUIRED) & cgbad & (bad_inc == 4'(BAD_LIMIT)));

   assign realign = signal_ok & comma &
                    ((state == LOSS_OF_SYNC) |
                     ((state == ACQUIRE_SYNC)  & cggood) |
                     ((state == SYNC_ACQUIRED) & cggood));

   assign sync_state = state;

   always_ff @(posedge RX_CLK or negedge mr_main_reset_n) begin
      if (!mr_main_reset_n) begin
         state            <= LOSS_OF_SYNC;
         sync_code_group  <= 10'd0;
         sync_even        <= 1'b0;
         code_sync_status <= 1'b0;
         comma_cnt        <= 3'd0;
         good_cnt         <= 4'd0;
         bad_cnt          <= 4'd0;
      end else begin
         sync_code_group <= rx_code_group;
         sync_even       <= realign ? 1'b1 : ~sync_even;
         if (go_loss) begin
            state            <= LOSS_OF_SYNC;
            code_sync_status <= 1'b0;
            comma_cnt        <= 3'd0;
            good_cnt         <= 4'd0;
            bad_cnt          <= 4'd0;
         end else begin
            case (state)
               LOSS_OF_SYNC: begin
                  if (comma) begin
                     state     <= COMMA_DETECT;
                     comma_cnt <= 3'd1;
                  end
               end
               COMMA_DETECT: begin
                  // go_loss already filtered out anything but a valid data code-group
                  if (comma_cnt == 3'(ACQ_COMMAS)) begin
                     state            <= SYNC_ACQUIRED;
                     code_sync_status <= 1'b1;
                  end else begin
                     state <= ACQUIRE_SYNC;
                  end
               end
               ACQUIRE_SYNC: begin
                  if (comma) begin
                     state     <= COMMA_DETECT;
                     comma_cnt <= comma_cnt + 3'd1;
                  end
               end
               SYNC_ACQUIRED: begin
                  if (cgbad) begin
                     good_cnt <= 4'd0;
                     bad_cnt  <= bad_inc;
                  end else if (bad_cnt != 4'd0) begin
                     if (good_inc == 4'(GOOD_CGS)) begin
                        bad_cnt  <= bad_cnt - 4'd1;
                        good_cnt <= 4'd0;
                     end else begin
                        good_cnt <= good_inc;
                     end
                  end else begin
                     good_cnt <= 4'd0;
                  end
               end
               default: state <= LOSS_OF_SYNC;
            endcase
         end
      end
   end

`ifdef PCS_SYNC_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge RX_CLK or negedge mr_main_reset_n) begin
      if (!mr_main_reset_n) begin
         loss_count   <= '0;
         bad_cg_count <= '0;
      end else begin
         if ((state == SYNC_ACQUIRED) && go_loss && (loss_count != {CNT_W{1'b1}}))
            loss_count <= loss_count + CNT_ONE;
         if ((state == SYNC_ACQUIRED) && cgbad && (bad_cg_count != {CNT_W{1'b1}}))
            bad_cg_count <= bad_cg_count + CNT_ONE;
      end
   end
`endif

endmodule

// File: doc/pcs_sync_multi.md
# pcs_sync_multi

Parametrised 1000BASE-X PCS code-group synchronization block. It sits on the receive path between the 10-bit `rx_code_group` input (loopback or SerDes) and the PCS receive state machine. It implements the Clause 36 synchronization process generalised in three ways: a programmable comma count for acquisition, a programmable good-run length, and a programmable bad-code-group loss threshold. It also provides optional statistics counters. With default parameters its behaviour is identical to Clause 36 Figure 36-9.

## Interface
Parameters:
- `ACQ_COMMAS`, 3: consecutive well-placed commas needed to acquire sync; legal range 1..7.
- `GOOD_CGS`, 4: consecutive good code-groups needed to decrement the bad count; legal range 1..15.
- `BAD_LIMIT`, 4: bad count at which sync is lost; legal range 1..15.
- `CNT_W`, 16: statistics counter width.

Ports:
- `RX_CLK`  in  1: single clock; all logic sits on its rising edge.
- `mr_main_reset_n`  in  1: reset, asynchronous and active-low.
- `signal_detect`  in  1: PMD signal present.
- `mr_loopback`  in  1: when 1, `signal_detect` is treated as 1.
- `rx_code_group`  in  10: received code-group; bit 9 is `a`, bit 0 is `j`.
- `cg_invalid`  in  1: decoder flags `rx_code_group` as not in the valid table (same cycle).
- `sync_code_group`  out  10: `rx_code_group` registered.
- `sync_even`  out  1: `rx_even`, aligned with `sync_code_group`.
- `code_sync_status`  out  1: 1 when sync is acquired.
- `sync_state`  out  2: 0 = LOSS_OF_SYNC, 1 = COMMA_DETECT, 2 = ACQUIRE_SYNC, 3 = SYNC_ACQUIRED.
- `loss_count`  out  CNT_W: present only with the macro.
- `bad_cg_count`  out  CNT_W: present only with the macro.

## Operation
Definitions:
- `signal_ok` = `signal_detect` | `mr_loopback`.
- `comma` = `rx_code_group[9:3]` is 7'b0011111 or 7'b1100000.
- `cgbad` = `cg_invalid` | (`comma` & `rx_even`==1), where `rx_even` is the value before this cycle's update.
- `cggood` = !`cgbad`.

Global rule: `signal_ok`==0 in any state forces LOSS_OF_SYNC on the next edge, with all internal counters cleared.

States:
- LOSS_OF_SYNC:
  - `code_sync_status`=0; `rx_even` toggles every cycle.
  - On `comma`: go to COMMA_DETECT, set `rx_even`=1, set `comma_cnt`=1.
- COMMA_DETECT (the code-group after a comma):
  - If it is a valid non-comma (data): toggle `rx_even`; go to SYNC_ACQUIRED if `comma_cnt`==`ACQ_COMMAS`, else to ACQUIRE_SYNC.
  - Otherwise go to LOSS_OF_SYNC.
- ACQUIRE_SYNC:
  - `cgbad` → LOSS_OF_SYNC.
  - `comma` & !`cgbad` → COMMA_DETECT, with `rx_even`=1 and `comma_cnt`+1.
  - Otherwise toggle `rx_even`.
- SYNC_ACQUIRED:
  - `code_sync_status`=1; `rx_even` toggles, or is set to 1 on a good comma.
  - `cgbad`: `good_cnt`←0 and `bad_cnt`+1. If the new `bad_cnt`==`BAD_LIMIT`, go to LOSS_OF_SYNC.
  - `cggood` with `bad_cnt`>0: `good_cnt`+1. When `good_cnt` reaches `GOOD_CGS`, `bad_cnt`−1 and `good_cnt`←0.
  - `cggood` with `bad_cnt`==0: `good_cnt` holds at 0.

Counter rules:
- `comma_cnt` is 3 bits; it never exceeds `ACQ_COMMAS` because reaching the limit transitions out.
- `bad_cnt` and `good_cnt` are 4 bits each and cannot wrap.

Simultaneous events:
- `signal_ok` loss has priority over every other condition.
- Reaching `BAD_LIMIT` has priority over the comma realignment.

## Timing
- Reset values: state LOSS_OF_SYNC, `sync_code_group`=0, `sync_even`=0, `code_sync_status`=0, all counters 0. Reset clears asynchronously mid-operation; the first evaluation occurs on the first edge after deassertion.
- Latency: 1 cycle. `sync_code_group`, `sync_even`, `code_sync_status` and `sync_state` update on the same edge and describe the code-group now on `sync_code_group`.
- `code_sync_status` rises on the edge that registers the data code-group following the `ACQ_COMMAS`-th comma.
- `code_sync_status` falls on the edge that registers the `BAD_LIMIT`-th bad code-group.
- No handshake: one code-group is consumed every cycle.

## Configuration
- `PCS_SYNC_STATS_EN` defined:
  - `loss_count` increments on each SYNC_ACQUIRED→LOSS_OF_SYNC transition.
  - `bad_cg_count` increments on each `cgbad` while in SYNC_ACQUIRED.
  - Both saturate at all-ones and reset to 0.
- `PCS_SYNC_STATS_EN` undefined: both ports and their logic are absent; all other behaviour is unchanged.

## Test plan
- Reset, `signal_detect`=1, stream K28.5(0011111010)/D16.2(1001000101) repeated → `code_sync_status`=1 on the edge registering the D16.2 after the 3rd comma; `sync_even`=1 on every K28.5.
- Synced, then 4 consecutive `cg_invalid`=1 → `code_sync_status`=0 on the 4th bad code-group's output edge; `loss_count`=1.
- Synced: 3 bad, 4 good, 1 bad → still synced (`bad_cnt`=3); one more bad → loss.
- During acquisition, a K28.5 arrives when `rx_even`=1 (comma at an odd position) → `sync_state`=0 and `code_sync_status` stays 0.
- Synced with `mr_loopback`=0, `signal_detect` drops for 1 cycle → loss on the next edge. Repeat with `mr_loopback`=1 → sync is kept.
- `ACQ_COMMAS`=5, `BAD_LIMIT`=2 → sync after the 5th comma; loss after 2 consecutive bad; `bad_cg_count`=2.
